uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  Frame-level controller downstream of the UART byte receiver. Consumes the byte strobe and
//  data from the receiver and parses frames of the form SYNC | ADDR | LEN | PAYLOAD[LEN] | CHK.
//  It streams payload bytes for matching addresses and reports frame OK or error.
//  It supervises inter-byte gaps on the shared oversampling tick (s_tick).
// PARAMETERS
//  SYNC_BYTE      8'hA5  frame start marker
//  MY_ADDR        8'h01  node address; 8'hFF is always accepted as broadcast
//  MAX_LEN        16     maximum payload length, in bytes (1..255)
//  TIMEOUT_TICKS  640    s_tick count allowed between bytes inside a frame (4 byte times at 16x)
//  TW             16     timeout counter width; TIMEOUT_TICKS < 2**TW
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  s_tick        in   1  oversampling tick from the baud generator
//  rx_done_tick  in   1  one-cycle strobe: a received byte is valid on rx_data
//  rx_data       in   8  received byte
//  out_valid     out  1  one-cycle strobe: payload byte on out_data
//  out_data      out  8  payload byte
//  out_first     out  1  qualifies out_valid: first payload byte
//  out_last      out  1  qualifies out_valid: last payload byte
//  out_addr      out  8  ADDR of the current frame; held until the next ADDR
//  frame_ok      out  1  one-cycle strobe: matching frame completed, checksum good
//  frame_err     out  1  one-cycle strobe: matching frame aborted; cause on err_code
//  err_code      out  2  01 = LEN > MAX_LEN, 10 = bad checksum, 11 = timeout; held until next error
//  busy          out  1  high in every state except HUNT
// BEHAVIOUR
//  - Reset: state HUNT. All outputs are 0. Checksum, byte counter and timeout counter are cleared.
//  - All outputs are registered. Each strobe appears 1 cycle after the causing rx_done_tick.
//  - There is no back-pressure. The consumer must accept every out_valid.
//  - FSM, where "byte" means rx_done_tick=1:
//     HUNT: on byte == SYNC_BYTE -> ADDR; clear chk. Other bytes are ignored silently.
//     ADDR: byte -> LEN; latch out_addr; chk = byte; match = (byte == MY_ADDR || byte == 8'hFF).
//     LEN:  byte -> PAYLOAD if 0 < byte <= MAX_LEN; -> CHK if byte == 0;
//           byte > MAX_LEN -> HUNT with err 01. In all cases chk ^= byte; cnt = byte.
//     PAYLOAD: byte -> chk ^= byte; cnt -= 1.
//              If match: out_valid = 1; out_first = (first byte); out_last = (cnt == 1).
//              When cnt reaches 0 -> CHK.
//     CHK:  byte -> HUNT. frame_ok if byte == chk, else err 10.
//  - Checksum is the 8-bit XOR of ADDR, LEN and all payload bytes. It excludes SYNC and CHK.
//  - Non-matching frames are tracked to the end but are silent: no out_*, frame_ok or frame_err.
//  - Timeout: outside HUNT, the counter increments on each s_tick and clears on each byte.
//    On reaching TIMEOUT_TICKS -> HUNT with err 11.
//  - Simultaneous rx_done_tick and terminal timeout tick: the byte wins; the counter clears.
//  - A SYNC_BYTE value inside a frame is treated as data. There is no resynchronisation mid-frame.
//  - After an error, out_valid bytes already issued stand. The consumer discards them on frame_err.
//  - Asserting reset mid-frame aborts the frame silently: no frame_err.
//  - frame_ok and frame_err are mutually exclusive, and never coincide with out_valid.
// STRUCTURE
//  - Shared package uart_pkg holds:
//     - frame-state enum: HUNT, ADDR, LEN, PAYLOAD, CHK;
//     - err_code localparams: ERR_NONE, ERR_LEN, ERR_CHK, ERR_TMO;
//     - the default SYNC_BYTE and BCAST_ADDR (8'hFF).
//  - One sub-module: uart_tick_timer (TW-bit counter with clear, s_tick enable, expired pulse).
//    It is reusable for the TX-side watchdog.
//  - The FSM, checksum and byte counter stay in this module, using a two-process style:
//    a state register plus next-state logic.
// TESTING
//  - A5 01 03 10 20 30 02 -> out_valid x3 (10,20,30); first on 10, last on 30;
//    frame_ok 1 cycle after the CHK byte.
//  - A5 01 02 AA BB 00 (bad CHK) -> 2 payload strobes, then frame_err with err_code=10.
//  - A5 01 20 (LEN 32 > MAX_LEN) -> frame_err with err_code=01, back to HUNT;
//    a following valid frame decodes OK.
//  - A5 01 02 55, then silence of 640 s_ticks -> frame_err with err_code=11, busy drops;
//    a byte on the 640th tick -> no timeout.
//  - A5 07 01 99 9F (other address) -> no outputs.
//    A5 FF 00 FF (broadcast, LEN 0) -> frame_ok only.
//  - Junk 00 13 A4, then reset pulse mid-payload -> all outputs 0 and HUNT;
//    no frame_err; the next frame decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART frame-layer definitions: frame FSM states, error codes and default marker bytes.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        ADDR    = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4
    } frame_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CHK  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] BCAST_ADDR    = 8'hFF;

endpackage

// File: rtl/uart_tick_timer.sv
// Tick-driven watchdog: counts tick while enabled, clear wins over tick, expired pulses on the
// tick that would reach LIMIT (combinational, same cycle as that tick); no backpressure.
module uart_tick_timer #(
    parameter int TW    = 16,
    parameter int LIMIT = 640
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [TW-1:0] TERM = TW'(LIMIT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && !clear && tick && (count == TERM);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser SYNC|ADDR|LEN|PAYLOAD|CHK over the UART byte strobe; every strobe is registered,
// one cycle after the causing byte or timeout tick; no backpressure, consumer takes every byte.
module uart_rx_frame_ctrl import uart_pkg::*; #(
    parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
    parameter logic [7:0] MY_ADDR       = 8'h01,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 640,
    parameter int         TW            = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_first,
    output logic       out_last,
    output logic [7:0] out_addr,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t state, state_next;
    logic [7:0]   chk;
    logic [7:0]   cnt;
    logic         match;
    logic         first_pend;
    logic         tmo_expired;

    uart_tick_timer #(
        .TW    (TW),
        .LIMIT (TIMEOUT_TICKS)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .enable  (state != HUNT),
        .clear   (rx_done_tick),
        .tick    (s_tick),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // tmo_expired is already masked by rx_done_tick, so a byte always wins the tie
    always_comb begin
        state_next = state;
        if (tmo_expired) begin
            state_next = HUNT;
        end else if (rx_done_tick) begin
            case (state)
                HUNT:    if (rx_data == SYNC_BYTE) state_next = ADDR;
                ADDR:    state_next = LEN;
                LEN: begin
                    if (rx_data > MAX_LEN_B)    state_next = HUNT;
                    else if (rx_data == 8'd0)   state_next = CHK;
                    else                        state_next = PAYLOAD;
                end
                PAYLOAD: if (cnt == 8'd1) state_next = CHK;
                CHK:     state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk        <= 8'd0;
            cnt        <= 8'd0;
            match      <= 1'b0;
            first_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'd0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_addr   <= 8'd0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (tmo_expired) begin
                if (match) begin
                    frame_err <= 1'b1;
                    err_code  <= ERR_TMO;
                end
            end else if (rx_done_tick) begin
                case (state)
                    HUNT: begin
                        if (rx_data == SYNC_BYTE) chk <= 8'd0;
                    end
                    ADDR: begin
                        out_addr <= rx_data;
                        chk      <= rx_data;
                        match    <= (rx_data == MY_ADDR) || (rx_data == BCAST_ADDR);
                    end
                    LEN: begin
                        chk        <= chk ^ rx_data;
                        cnt        <= rx_data;
                        first_pend <= 1'b1;
                        if (rx_data > MAX_LEN_B && match) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                        end
                    end
                    PAYLOAD: begin
                        chk        <= chk ^ rx_data;
                        cnt        <= cnt - 8'd1;
                        first_pend <= 1'b0;
                        if (match) begin
                            out_valid <= 1'b1;
                            out_data  <= rx_data;
                            out_first <= first_pend;
                            out_last  <= (cnt == 8'd1);
                        end
                    end
                    CHK: begin
                        if (match) begin
                            if (rx_data == chk) begin
                                frame_ok <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_CHK;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected strobes queued as bytes are sent, popped on output.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_first;
    logic       out_last;
    logic [7:0] out_addr;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stim_cyc = 0;

    typedef struct {
        logic [2:0] kind;   // one-hot {out_valid, frame_ok, frame_err}
        logic [7:0] data;
        logic       first;
        logic       last;
        logic [1:0] err;
    } exp_t;

    exp_t exp_q[$];

    uart_rx_frame_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_first    (out_first),
        .out_last     (out_last),
        .out_addr     (out_addr),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void exp_data(input logic [7:0] d, input logic f, input logic l);
        exp_t e;
        e.kind = 3'b100; e.data = d; e.first = f; e.last = l; e.err = 2'b00;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_ok();
        exp_t e;
        e.kind = 3'b010; e.data = 8'd0; e.first = 1'b0; e.last = 1'b0; e.err = 2'b00;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_err(input logic [1:0] code);
        exp_t e;
        e.kind = 3'b001; e.data = 8'd0; e.first = 1'b0; e.last = 1'b0; e.err = code;
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every strobe must match the head of the queue and land one cycle after its cause
    always @(negedge clk) begin
        if (!reset && (out_valid || frame_ok || frame_err)) begin
            logic [2:0] obs;
            exp_t e;
            obs = {out_valid, frame_ok, frame_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got kind=%b data=%h err=%b, required no output", obs, out_data, err_code);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e.kind) begin
                    errors++;
                    $display("FAIL strobe_kind: got %b, required %b", obs, e.kind);
                end else if (e.kind == 3'b100 && {out_data, out_first, out_last} !== {e.data, e.first, e.last}) begin
                    errors++;
                    $display("FAIL payload: got data=%h first=%b last=%b, required data=%h first=%b last=%b",
                             out_data, out_first, out_last, e.data, e.first, e.last);
                end else if (e.kind == 3'b001 && err_code !== e.err) begin
                    errors++;
                    $display("FAIL err_code: got %b, required %b", err_code, e.err);
                end else if (cyc != stim_cyc + 1) begin
                    errors++;
                    $display("FAIL strobe_latency: got %0d cycles, required 1", cyc - stim_cyc);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic tk);
        rx_done_tick = 1'b1;
        rx_data      = b;
        s_tick       = tk;
        stim_cyc     = cyc;
        @(negedge clk);
        rx_done_tick = 1'b0;
        s_tick       = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_tick   = 1'b1;
            stim_cyc = cyc;
            @(negedge clk);
            s_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_first, out_last, out_addr, frame_ok, frame_err, err_code, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h addr=%h ok=%b err=%b code=%b busy=%b, required all 0",
                     out_valid, out_data, out_addr, frame_ok, frame_err, err_code, busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_good_frame();
        exp_data(8'h10, 1'b1, 1'b0);
        exp_data(8'h20, 1'b0, 1'b0);
        exp_data(8'h30, 1'b0, 1'b1);
        exp_ok();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        checks++;
        if (out_addr !== 8'h01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL good_addr_busy: got addr=%h busy=%b, required addr=01 busy=1", out_addr, busy);
        end
        send_byte(8'h03, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h02, 1'b0);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL good_frame_done: got pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_bad_checksum();
        exp_data(8'hAA, 1'b1, 1'b0);
        exp_data(8'hBB, 1'b0, 1'b1);
        exp_err(2'b10);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++;
        if (exp_q.size() != 0 || err_code !== 2'b10) begin
            errors++;
            $display("FAIL bad_chk_done: got pending=%0d code=%b, required 0 and 10", exp_q.size(), err_code);
        end
    endtask

    task automatic test_len_error();
        exp_err(2'b01);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h20, 1'b0);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || err_code !== 2'b01) begin
            errors++;
            $display("FAIL len_err_done: got pending=%0d busy=%b code=%b, required 0 0 01", exp_q.size(), busy, err_code);
        end
        // Recovery frame: checksum 01^01^42 = 42
        exp_data(8'h42, 1'b1, 1'b1);
        exp_ok();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h42, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL len_recovery: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        exp_data(8'h55, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h55, 1'b0);
        ticks(639);
        checks++;
        if (busy !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL tmo_before_limit: got busy=%b pending=%0d, required 1 and 0", busy, exp_q.size());
        end
        exp_err(2'b11);
        ticks(1);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0 || err_code !== 2'b11) begin
            errors++;
            $display("FAIL tmo_expire: got busy=%b pending=%0d code=%b, required 0 0 11", busy, exp_q.size(), err_code);
        end
        // Byte on the terminal tick keeps the frame alive; checksum 01^02^55^66 = 30
        exp_data(8'h55, 1'b1, 1'b0);
        exp_data(8'h66, 1'b0, 1'b1);
        exp_ok();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h55, 1'b0);
        ticks(639);
        send_byte(8'h66, 1'b1);
        ticks(639);
        send_byte(8'h30, 1'b0);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_tie_byte_wins: got pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_addr_filter();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h07, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h99, 1'b0);
        checks++;
        if (busy !== 1'b1 || out_addr !== 8'h07) begin
            errors++;
            $display("FAIL other_addr_tracked: got busy=%b addr=%h, required 1 and 07", busy, out_addr);
        end
        send_byte(8'h9F, 1'b0);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0 || err_code !== 2'b11) begin
            errors++;
            $display("FAIL other_addr_silent: got busy=%b pending=%0d code=%b, required 0 0 11", busy, exp_q.size(), err_code);
        end
        exp_ok();
        send_byte(8'hA5, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        checks++;
        if (exp_q.size() != 0 || out_addr !== 8'hFF) begin
            errors++;
            $display("FAIL broadcast_len0: got pending=%0d addr=%h, required 0 and FF", exp_q.size(), out_addr);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'hA4, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL junk_ignored: got busy=%b, required 0", busy);
        end
        exp_data(8'h10, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h10, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_first, out_last, out_addr, frame_ok, frame_err, err_code, busy} !== '0
            || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_frame: got valid=%b addr=%h err=%b code=%b busy=%b pending=%0d, required all 0",
                     out_valid, out_addr, frame_err, err_code, busy, exp_q.size());
        end
        exp_data(8'h10, 1'b1, 1'b0);
        exp_data(8'h20, 1'b0, 1'b0);
        exp_data(8'h30, 1'b0, 1'b1);
        exp_ok();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h02, 1'b0);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_frame: got pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_len_error();
        test_timeout();
        test_addr_filter();
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
